// File: rtl/pkt_pacer.sv
// pkt_pacer: buffers packets in an input FIFO and releases them with a
// software-programmed minimum inter-packet gap (in clock cycles).
// Register block: SW reg 0 = {pace_en[31], gap[GAP_WIDTH-1:0]},
// HW reg 0 = pkt_count, HW reg 1 = stall_cycles (only when the
// PKT_PACER_STALL_CNT_EN macro is defined; otherwise the map ends at pkt_count).
// Register word index: 0 = ctrl, 1 = pkt_count, 2 = stall_cycles.

`ifndef UDP_REG_ADDR_WIDTH
`define UDP_REG_ADDR_WIDTH 23
`endif
`ifndef CPCI_NF2_DATA_WIDTH
`define CPCI_NF2_DATA_WIDTH 32
`endif
`ifndef PKT_PACER_REG_ADDR_WIDTH
`define PKT_PACER_REG_ADDR_WIDTH 6
`endif
`ifndef PKT_PACER_BLOCK_ADDR
`define PKT_PACER_BLOCK_ADDR 17'h00042
`endif

module pkt_pacer #(
    parameter int unsigned DATA_WIDTH        = 64,
    parameter int unsigned CTRL_WIDTH        = 8,
    parameter int unsigned UDP_REG_SRC_WIDTH = 3,
    parameter int unsigned GAP_WIDTH         = 16,
    parameter int unsigned FIFO_DEPTH_BITS   = 5
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [DATA_WIDTH-1:0]               in_data,
    input  logic [CTRL_WIDTH-1:0]               in_ctrl,
    input  logic                                in_wr,
    output logic                                in_rdy,
    output logic [DATA_WIDTH-1:0]               out_data,
    output logic [CTRL_WIDTH-1:0]               out_ctrl,
    output logic                                out_wr,
    input  logic                                out_rdy,
    input  logic                                reg_req_in,
    input  logic                                reg_ack_in,
    input  logic                                reg_rd_wr_L_in,
    input  logic [`UDP_REG_ADDR_WIDTH-1:0]      reg_addr_in,
    input  logic [`CPCI_NF2_DATA_WIDTH-1:0]     reg_data_in,
    input  logic [UDP_REG_SRC_WIDTH-1:0]        reg_src_in,
    output logic                                reg_req_out,
    output logic                                reg_ack_out,
    output logic                                reg_rd_wr_L_out,
    output logic [`UDP_REG_ADDR_WIDTH-1:0]      reg_addr_out,
    output logic [`CPCI_NF2_DATA_WIDTH-1:0]     reg_data_out,
    output logic [UDP_REG_SRC_WIDTH-1:0]        reg_src_out
);

    localparam int unsigned FIFO_DEPTH = 2 ** FIFO_DEPTH_BITS;
    localparam int unsigned FW         = CTRL_WIDTH + DATA_WIDTH;
    localparam logic [FIFO_DEPTH_BITS:0] C_FULL   = {1'b1, {FIFO_DEPTH_BITS{1'b0}}};
    localparam logic [FIFO_DEPTH_BITS:0] C_NEARLY = {1'b0, {FIFO_DEPTH_BITS{1'b1}}};
    localparam logic [`PKT_PACER_REG_ADDR_WIDTH-1:0] RA_CTRL  = 0;
    localparam logic [`PKT_PACER_REG_ADDR_WIDTH-1:0] RA_PKT   = 1;
`ifdef PKT_PACER_STALL_CNT_EN
    localparam logic [`PKT_PACER_REG_ADDR_WIDTH-1:0] RA_STALL = 2;
`endif

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_BODY, S_GAP} state_t;

    state_t                      r_state, w_next;
    logic [FW-1:0]               r_mem [FIFO_DEPTH];
    logic [FIFO_DEPTH_BITS-1:0]  r_wr_ptr, r_rd_ptr;
    logic [FIFO_DEPTH_BITS:0]    r_count;
    logic [GAP_WIDTH-1:0]        r_gap_cnt, r_gap;
    logic                        r_pace_en;
    logic [31:0]                 r_pkt_count;
    logic                        w_empty, w_full, w_fifo_wr, w_word_go, w_eop, w_to_gap;
    logic [FW-1:0]               w_head;
    logic                        w_reg_hit;
    logic [`PKT_PACER_REG_ADDR_WIDTH-1:0]  w_reg_idx;
    logic [`CPCI_NF2_DATA_WIDTH-1:0]       w_ctrl_rd, w_rd_data;
`ifdef PKT_PACER_STALL_CNT_EN
    logic [31:0]                 r_stall;
`endif

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == C_FULL);
    assign w_fifo_wr = in_wr && !w_full;
    assign in_rdy    = !(r_count >= C_NEARLY);
    assign w_head    = r_mem[r_rd_ptr];
    assign out_ctrl  = w_head[FW-1:DATA_WIDTH];
    assign out_data  = w_head[DATA_WIDTH-1:0];
    assign out_wr    = w_word_go;
    assign w_to_gap  = r_pace_en && (r_gap != '0);

    // FIFO storage: written on every accepted input word
    always_ff @(posedge clk) begin
        if (w_fifo_wr) r_mem[r_wr_ptr] <= {in_ctrl, in_data};
    end

    // FIFO pointers and occupancy; a simultaneous read and write leave occupancy unchanged
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_fifo_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_word_go) r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_fifo_wr && !w_word_go)      r_count <= r_count + 1'b1;
            else if (!w_fifo_wr && w_word_go) r_count <= r_count - 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // FSM next state, FIFO read enable and EOP detection
    always_comb begin
        w_next    = r_state;
        w_word_go = 1'b0;
        w_eop     = 1'b0;
        case (r_state)
            S_IDLE, S_HDR: begin
                if (!w_empty && out_rdy) begin
                    w_word_go = 1'b1;
                    if (out_ctrl == '1)      w_next = S_HDR;
                    else if (out_ctrl == '0) w_next = S_BODY;
                    else                     w_eop  = 1'b1;
                end
            end
            S_BODY: begin
                if (!w_empty && out_rdy) begin
                    w_word_go = 1'b1;
                    if (out_ctrl != '0 && out_ctrl != '1) w_eop = 1'b1;
                end
            end
            S_GAP: begin
                if (r_gap_cnt == GAP_WIDTH'(1)) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        if (w_eop) w_next = w_to_gap ? S_GAP : S_IDLE;
    end

    // Gap down-counter (snapshots gap at EOP) and packet counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_gap_cnt   <= '0;
            r_pkt_count <= '0;
        end else begin
            if (w_eop) r_pkt_count <= r_pkt_count + 1'b1;
            if (w_eop && w_to_gap)    r_gap_cnt <= r_gap;
            else if (r_state == S_GAP) r_gap_cnt <= r_gap_cnt - 1'b1;
        end
    end

`ifdef PKT_PACER_STALL_CNT_EN
    // Saturating count of gap cycles spent with data waiting in the FIFO
    always_ff @(posedge clk) begin
        if (reset) r_stall <= '0;
        else if (r_state == S_GAP && !w_empty && r_stall != '1) r_stall <= r_stall + 1'b1;
    end
`endif

    assign w_reg_idx = reg_addr_in[`PKT_PACER_REG_ADDR_WIDTH-1:0];
    assign w_reg_hit = reg_req_in && !reg_ack_in &&
        (reg_addr_in[`UDP_REG_ADDR_WIDTH-1:`PKT_PACER_REG_ADDR_WIDTH] == `PKT_PACER_BLOCK_ADDR);

    // Register read-back mux; unmapped words in this block read as 0xDEADBEEF
    always_comb begin
        w_ctrl_rd                  = '0;
        w_ctrl_rd[31]              = r_pace_en;
        w_ctrl_rd[GAP_WIDTH-1:0]   = r_gap;
        w_rd_data                  = 32'hDEAD_BEEF;
        if (w_reg_idx == RA_CTRL)     w_rd_data = w_ctrl_rd;
        else if (w_reg_idx == RA_PKT) w_rd_data = r_pkt_count;
`ifdef PKT_PACER_STALL_CNT_EN
        else if (w_reg_idx == RA_STALL) w_rd_data = r_stall;
`endif
    end

    // Software control register write
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pace_en <= 1'b0;
            r_gap     <= '0;
        end else if (w_reg_hit && !reg_rd_wr_L_in && w_reg_idx == RA_CTRL) begin
            r_pace_en <= reg_data_in[31];
            r_gap     <= reg_data_in[GAP_WIDTH-1:0];
        end
    end

    // Register chain stage: answer hits in this block, pass everything else through
    always_ff @(posedge clk) begin
        if (reset) begin
            reg_req_out     <= 1'b0;
            reg_ack_out     <= 1'b0;
            reg_rd_wr_L_out <= 1'b0;
            reg_addr_out    <= '0;
            reg_data_out    <= '0;
            reg_src_out     <= '0;
        end else begin
            reg_req_out     <= reg_req_in;
            reg_rd_wr_L_out <= reg_rd_wr_L_in;
            reg_addr_out    <= reg_addr_in;
            reg_src_out     <= reg_src_in;
            if (w_reg_hit) begin
                reg_ack_out  <= 1'b1;
                reg_data_out <= reg_rd_wr_L_in ? w_rd_data : reg_data_in;
            end else begin
                reg_ack_out  <= reg_ack_in;
                reg_data_out <= reg_data_in;
            end
        end
    end

endmodule

// File: tb/tb_pkt_pacer.sv
// tb_pkt_pacer: scoreboard bench for pkt_pacer. Stimulus pushes expected
// words (with packet start/end marks) into a queue; a negedge monitor pops
// and compares every output word and checks inter-packet spacing against
// the gap value software had programmed when the previous packet ended.
`timescale 1ns/1ps

`ifndef UDP_REG_ADDR_WIDTH
`define UDP_REG_ADDR_WIDTH 23
`endif
`ifndef CPCI_NF2_DATA_WIDTH
`define CPCI_NF2_DATA_WIDTH 32
`endif
`ifndef PKT_PACER_REG_ADDR_WIDTH
`define PKT_PACER_REG_ADDR_WIDTH 6
`endif
`ifndef PKT_PACER_BLOCK_ADDR
`define PKT_PACER_BLOCK_ADDR 17'h00042
`endif

module tb_pkt_pacer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] in_data = '0;
    logic [7:0]  in_ctrl = '0;
    logic        in_wr = 1'b0;
    logic        in_rdy;
    logic [63:0] out_data;
    logic [7:0]  out_ctrl;
    logic        out_wr;
    logic        out_rdy = 1'b0;
    logic        reg_req_in = 1'b0, reg_ack_in = 1'b0, reg_rd_wr_L_in = 1'b0;
    logic [`UDP_REG_ADDR_WIDTH-1:0]  reg_addr_in = '0;
    logic [`CPCI_NF2_DATA_WIDTH-1:0] reg_data_in = '0;
    logic [2:0]  reg_src_in = '0;
    logic        reg_req_out, reg_ack_out, reg_rd_wr_L_out;
    logic [`UDP_REG_ADDR_WIDTH-1:0]  reg_addr_out;
    logic [`CPCI_NF2_DATA_WIDTH-1:0] reg_data_out;
    logic [2:0]  reg_src_out;

    pkt_pacer #(.DATA_WIDTH(64), .CTRL_WIDTH(8), .UDP_REG_SRC_WIDTH(3),
                .GAP_WIDTH(16), .FIFO_DEPTH_BITS(5)) dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr), .in_rdy(in_rdy),
        .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy),
        .reg_req_in(reg_req_in), .reg_ack_in(reg_ack_in), .reg_rd_wr_L_in(reg_rd_wr_L_in),
        .reg_addr_in(reg_addr_in), .reg_data_in(reg_data_in), .reg_src_in(reg_src_in),
        .reg_req_out(reg_req_out), .reg_ack_out(reg_ack_out), .reg_rd_wr_L_out(reg_rd_wr_L_out),
        .reg_addr_out(reg_addr_out), .reg_data_out(reg_data_out), .reg_src_out(reg_src_out));

    always #5 clk = ~clk;

    typedef struct { logic [63:0] data; logic [7:0] ctrl; bit sop; bit eop; } word_t;
    word_t exp_q[$];

    int errors = 0, checks = 0;
    int cyc = 0, eops = 0, eop_cyc = 0, prev_cyc = 0, gap_snap = 0;
    bit have_eop = 0, strict = 0;
    logic        sh_pace = 1'b0;
    logic [15:0] sh_gap = '0;
    int          rdy_mode = 0;
    logic        rdy_manual = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    task automatic check_ge(input string name, input int act, input int req_min);
        checks++;
        if (act < req_min) begin
            errors++;
            $display("FAIL %s: got %0d required >= %0d", name, act, req_min);
        end
    endtask

    // Downstream ready: manual, random, or toggling every cycle
    always @(posedge clk) begin
        #2;
        case (rdy_mode)
            0: out_rdy = rdy_manual;
            1: out_rdy = 1'($urandom_range(0, 1));
            default: out_rdy = ~out_rdy;
        endcase
    end

    // Monitor: compare each output word against the scoreboard and check spacing
    always @(negedge clk) begin : monitor
        word_t w;
        cyc++;
        if (reset) begin
            exp_q.delete();
            have_eop = 0;
            eops = 0;
        end else if (out_wr) begin
            check("wr_without_rdy", out_rdy, 1);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got ctrl 0x%0h data 0x%0h required none", out_ctrl, out_data);
            end else begin
                w = exp_q.pop_front();
                check("data", out_data, w.data);
                check("ctrl", out_ctrl, w.ctrl);
                if (w.sop && have_eop) begin
                    if (strict) check("gap_exact", 64'(cyc - eop_cyc), 64'(gap_snap + 1));
                    else        check_ge("gap_min", cyc - eop_cyc, gap_snap + 1);
                end else if (!w.sop && strict) begin
                    check("burst", 64'(cyc - prev_cyc), 64'd1);
                end
                if (w.eop) begin
                    have_eop = 1;
                    eop_cyc  = cyc;
                    gap_snap = (sh_pace && sh_gap != 0) ? int'(sh_gap) : 0;
                    eops++;
                end
                prev_cyc = cyc;
            end
        end
    end

    function automatic logic [`UDP_REG_ADDR_WIDTH-1:0] reg_addr(input int idx);
        logic [`UDP_REG_ADDR_WIDTH-1:0] a;
        a = '0;
        a[`UDP_REG_ADDR_WIDTH-1:`PKT_PACER_REG_ADDR_WIDTH] = `PKT_PACER_BLOCK_ADDR;
        a[1:0] = 2'(idx);
        return a;
    endfunction

    task automatic reg_wr(input int idx, input logic [31:0] val);
        reg_req_in = 1'b1; reg_rd_wr_L_in = 1'b0;
        reg_addr_in = reg_addr(idx); reg_data_in = val;
        @(posedge clk); #1;
        reg_req_in = 1'b0;
        check("reg_wr_ack", reg_ack_out, 1);
        if (idx == 0) begin sh_pace = val[31]; sh_gap = val[15:0]; end
    endtask

    task automatic reg_rd_check(input string name, input int idx, input logic [31:0] req);
        reg_req_in = 1'b1; reg_rd_wr_L_in = 1'b1;
        reg_addr_in = reg_addr(idx); reg_data_in = '0;
        @(posedge clk); #1;
        reg_req_in = 1'b0;
        check("reg_rd_ack", reg_ack_out, 1);
        check(name, reg_data_out, req);
    endtask

    task automatic send_word(input logic [63:0] d, input logic [7:0] c, input bit sop, input bit eop);
        int n;
        word_t w;
        n = 0;
        in_wr = 1'b0;
        while (!in_rdy && n < 2000) begin @(posedge clk); #1; n++; end
        if (!in_rdy) begin
            checks++; errors++;
            $display("FAIL in_rdy_timeout: got in_rdy=0 required 1 within 2000 cycles");
        end else begin
            in_wr = 1'b1; in_data = d; in_ctrl = c;
            w.data = d; w.ctrl = c; w.sop = sop; w.eop = eop;
            exp_q.push_back(w);
            @(posedge clk); #1;
            in_wr = 1'b0;
        end
    endtask

    task automatic send_pkt(input int nhdr, input int nbody, input logic [7:0] last);
        int len;
        len = nhdr + nbody + 1;
        for (int i = 0; i < len; i++)
            send_word({$urandom, $urandom},
                      (i < nhdr) ? 8'hff : (i == len - 1) ? last : 8'h00,
                      i == 0, i == len - 1);
    endtask

    task automatic wait_cond_drain(input int limit);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < limit) begin @(posedge clk); #1; n++; end
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout: got %0d words pending required 0", exp_q.size());
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic wait_eops(input int k, input int limit);
        int n;
        n = 0;
        while (eops < k && n < limit) begin @(posedge clk); #1; n++; end
        if (eops < k) begin
            checks++; errors++;
            $display("FAIL eop_timeout: got %0d packets required %0d", eops, k);
        end
    endtask

    task automatic do_reset();
        in_wr = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        sh_pace = 1'b0; sh_gap = '0; strict = 0;
        @(posedge clk); #1;
        check("rst_out_wr", out_wr, 0);
        check("rst_in_rdy", in_rdy, 1);
    endtask

    // Preload n 4-word packets with downstream stalled, then release
    task automatic preload_run(input int npkt);
        rdy_mode = 0; rdy_manual = 1'b0;
        @(posedge clk); #1;
        for (int p = 0; p < npkt; p++) send_pkt(1, 2, 8'h80);
        strict = 1;
        rdy_manual = 1'b1;
        wait_cond_drain(500);
        strict = 0;
    endtask

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        int total;
        // Directed: no gap, back-to-back
        do_reset();
        check("rst_out_wr_idle", out_wr, 0);
        reg_rd_check("ctrl_reset", 0, 32'h0);
        reg_rd_check("pkt_reset", 1, 32'h0);
        reg_wr(0, 32'h8000_0000);
        preload_run(2);
        reg_rd_check("pkt_gap0", 1, 32'd2);
`ifdef PKT_PACER_STALL_CNT_EN
        reg_rd_check("stall_gap0", 2, 32'd0);
`endif

        // Directed: gap of 10
        do_reset();
        reg_wr(0, 32'h8000_000a);
        preload_run(2);
        reg_rd_check("pkt_gap10", 1, 32'd2);
`ifdef PKT_PACER_STALL_CNT_EN
        reg_rd_check("stall_gap10", 2, 32'd10);
`endif

        // Directed: gap rewritten while a gap is running
        do_reset();
        reg_wr(0, 32'h8000_000a);
        rdy_mode = 0; rdy_manual = 1'b0;
        for (int p = 0; p < 3; p++) send_pkt(1, 2, 8'h80);
        strict = 1;
        rdy_manual = 1'b1;
        wait_eops(1, 200);
        reg_wr(0, 32'h8000_0003);
        wait_cond_drain(500);
        strict = 0;
        reg_rd_check("pkt_regap", 1, 32'd3);
`ifdef PKT_PACER_STALL_CNT_EN
        reg_rd_check("stall_regap", 2, 32'd13);
`endif

        // Directed: pacing disabled with a large gap programmed
        do_reset();
        reg_wr(0, 32'h0000_0064);
        preload_run(3);
        reg_rd_check("pkt_nopace", 1, 32'd3);
`ifdef PKT_PACER_STALL_CNT_EN
        reg_rd_check("stall_nopace", 2, 32'd0);
`endif

        // Directed: fill to nearly-full, then drain with toggling ready
        do_reset();
        rdy_mode = 0; rdy_manual = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 32; i++) begin
            check("in_rdy_fill", in_rdy, (i < 31) ? 64'd1 : 64'd0);
            if (i < 31) send_word({$urandom, $urandom}, (i == 0) ? 8'hff : 8'h00, i == 0, 0);
        end
        rdy_mode = 2;
        for (int i = 31; i < 40; i++)
            send_word({$urandom, $urandom}, (i == 39) ? 8'h80 : 8'h00, 0, i == 39);
        wait_cond_drain(500);
        rdy_mode = 0;
        reg_rd_check("pkt_fill", 1, 32'd1);

        // Reset mid-body
        do_reset();
        rdy_mode = 0; rdy_manual = 1'b0;
        send_pkt(1, 8, 8'h80);
        rdy_manual = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        do_reset();
        reg_rd_check("pkt_rst_body", 1, 32'd0);
        repeat (5) @(posedge clk);
        #1;
        check("fifo_flushed", out_wr, 0);
        preload_run(2);
        reg_rd_check("pkt_after_rst", 1, 32'd2);

        // Reset mid-gap
        reg_wr(0, 32'h8000_0014);
        rdy_mode = 0; rdy_manual = 1'b0;
        send_pkt(1, 2, 8'h80);
        send_pkt(1, 2, 8'h80);
        rdy_manual = 1'b1;
        wait_eops(1, 200);
        repeat (3) @(posedge clk);
        #1;
        do_reset();
        reg_rd_check("pkt_rst_gap", 1, 32'd0);
        reg_rd_check("ctrl_rst_gap", 0, 32'd0);
`ifdef PKT_PACER_STALL_CNT_EN
        reg_rd_check("stall_rst_gap", 2, 32'd0);
`endif
        preload_run(2);
        reg_rd_check("pkt_after_gap_rst", 1, 32'd2);

        // Randomized traffic with random ready and random pacing settings
        do_reset();
        total = 0;
        for (int b = 0; b < 6; b++) begin
            reg_wr(0, {1'($urandom_range(0, 1)), 15'd0, 16'($urandom_range(0, 12))});
            rdy_mode = 1;
            for (int p = 0; p < 5; p++) begin
                send_pkt($urandom_range(0, 2), $urandom_range(0, 6), 8'($urandom_range(1, 254)));
                total++;
            end
            wait_cond_drain(2000);
            rdy_mode = 0; rdy_manual = 1'b1;
        end
        reg_rd_check("pkt_random", 1, 32'(total));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
